// File: rtl/ff_gain_stage.sv
// Feed-forward gain stage: signed sample x fixed-point gain, round half up, saturate.
// Gain changes are deferred to the gaps between pulses; saturations are counted per pulse.
module ff_gain_stage #(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 7,
    parameter int SHIFT    = 4,
    parameter int GAIN_RST = 16,
    parameter int CNT_W    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     store_strb,
    input  logic signed [DATA_W-1:0] din,
    input  logic signed [COEF_W-1:0] gain,
    input  logic                     gain_wr,
    output logic signed [DATA_W-1:0] dout,
    output logic                     store_strb_out,
    output logic signed [COEF_W-1:0] gain_active,
    output logic                     gain_pending,
    output logic [CNT_W-1:0]         sat_count,
    output logic                     sat_flag
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic signed [PROD_W:0] RND_HALF = (PROD_W+1)'(2 ** (SHIFT-1));
    localparam logic signed [PROD_W:0] Q_MAX    = (PROD_W+1)'((2 ** (DATA_W-1)) - 1);
    localparam logic signed [PROD_W:0] Q_MIN    = ~Q_MAX;

    typedef enum logic [1:0] {IDLE, PULSE, DRAIN} state_t;

    function automatic logic signed [PROD_W:0] round_shift(input logic signed [PROD_W-1:0] p);
        logic signed [PROD_W:0] r;
        r = (PROD_W+1)'(p) + RND_HALF;
        return r >>> SHIFT;
    endfunction

    function automatic logic is_clamped(input logic signed [PROD_W:0] q);
        return (q > Q_MAX) || (q < Q_MIN);
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [PROD_W:0] q);
        if (q > Q_MAX) return {1'b0, {(DATA_W-1){1'b1}}};
        if (q < Q_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
        return q[DATA_W-1:0];
    endfunction

    logic signed [PROD_W-1:0] prod_p0;
    logic signed [PROD_W-1:0] prod_p1;
    logic signed [PROD_W:0]   q_p1;
    logic                     vld_p1;
    logic                     sat_p2;
    logic                     vld_p3;
    logic [CNT_W-1:0]         run_cnt;
    logic [CNT_W-1:0]         run_cnt_next;
    logic signed [COEF_W-1:0] gain_pend;
    logic [1:0]               drain_cnt;
    state_t                   state;

    // Stage 0 -> 1: gated product
    assign prod_p0 = store_strb ? PROD_W'(din) * PROD_W'(gain_active) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            prod_p1 <= prod_p0;
            vld_p1  <= store_strb;
        end
    end

    // Stage 1 -> 2: round, saturate, register output
    assign q_p1 = round_shift(prod_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout           <= '0;
            sat_p2         <= 1'b0;
            store_strb_out <= 1'b0;
            vld_p3         <= 1'b0;
        end else begin
            dout           <= saturate(q_p1);
            sat_p2         <= is_clamped(q_p1);
            store_strb_out <= vld_p1;
            vld_p3         <= store_strb_out;
        end
    end

    // Running count restarts on the first output sample of a pulse, which may itself be clamped
    always_comb begin
        run_cnt_next = run_cnt;
        if (store_strb_out && !vld_p3)
            run_cnt_next = CNT_W'(sat_p2);
        else if (store_strb_out && sat_p2 && (run_cnt != '1))
            run_cnt_next = run_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            gain_active  <= COEF_W'(GAIN_RST);
            gain_pend    <= '0;
            gain_pending <= 1'b0;
            run_cnt      <= '0;
            sat_count    <= '0;
            sat_flag     <= 1'b0;
        end else begin
            run_cnt <= run_cnt_next;
            case (state)
                IDLE: begin
                    if (store_strb) begin
                        state <= PULSE;
                    end else if (gain_pending) begin
                        gain_active  <= gain_pend;
                        gain_pending <= 1'b0;
                    end
                end
                PULSE: begin
                    if (!store_strb) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd2;
                    end
                end
                DRAIN: begin
                    if (store_strb) begin
                        sat_count <= run_cnt_next;
                        sat_flag  <= (run_cnt_next != '0);
                        state     <= PULSE;
                    end else if (drain_cnt == 2'd1) begin
                        sat_count <= run_cnt_next;
                        sat_flag  <= (run_cnt_next != '0);
                        state     <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A write landing on the apply cycle is kept pending for the next gap
            if (gain_wr) begin
                gain_pend    <= gain;
                gain_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ff_gain_stage.sv
// Directed bench for ff_gain_stage: expected output samples are queued at drive time
// and popped by a monitor whenever store_strb_out is high.
module tb_ff_gain_stage;
    logic               clk;
    logic               rst_n;
    logic               store_strb;
    logic signed [15:0] din;
    logic signed [6:0]  gain;
    logic               gain_wr;
    logic signed [15:0] dout;
    logic               store_strb_out;
    logic signed [6:0]  gain_active;
    logic               gain_pending;
    logic [9:0]         sat_count;
    logic               sat_flag;

    int n_tests = 0;
    int n_fail  = 0;
    int sbq[$];
    bit mon_en  = 1'b0;

    ff_gain_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .store_strb     (store_strb),
        .din            (din),
        .gain           (gain),
        .gain_wr        (gain_wr),
        .dout           (dout),
        .store_strb_out (store_strb_out),
        .gain_active    (gain_active),
        .gain_pending   (gain_pending),
        .sat_count      (sat_count),
        .sat_flag       (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: floor((d*g + 8) / 16), clamped to the 16-bit signed range
    function automatic int model(input int d, input int g);
        int v;
        int q;
        v = d * g + 8;
        if (v >= 0) q = v / 16;
        else        q = -((-v + 15) / 16);
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (store_strb_out) begin
                int exp_v;
                exp_v = (sbq.size() > 0) ? sbq.pop_front() : 99999;
                chk("sb_dout", int'(dout), exp_v);
            end else begin
                chk("dout_idle_zero", int'(dout), 0);
            end
        end
    end

    task automatic tick(input bit s, input int d, input int g_exp,
                        input bit wr = 1'b0, input int gv = 0);
        @(posedge clk);
        #1;
        store_strb = s;
        din        = 16'(d);
        gain_wr    = wr;
        gain       = 7'(gv);
        if (s) sbq.push_back(model(d, g_exp));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 0, 0);
    endtask

    task automatic set_gain(input int g, input int g_old);
        tick(1'b0, 0, 0, 1'b1, g);
        idle(1);
        chk("setg_pending", int'(gain_pending), 1);
        chk("setg_old_active", int'(gain_active), g_old);
        idle(1);
        chk("setg_active", int'(gain_active), g);
        chk("setg_cleared", int'(gain_pending), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; store_strb = 1'b0; din = '0; gain = '0; gain_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_strb_out", int'(store_strb_out), 0);
        chk("rst_gain_active", int'(gain_active), 16);
        chk("rst_pending", int'(gain_pending), 0);
        chk("rst_sat_count", int'(sat_count), 0);
        chk("rst_sat_flag", int'(sat_flag), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Test 1: unity gain, latency and alignment
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1000, 16);
            chk("t1_latency", int'(store_strb_out), (i >= 2) ? 1 : 0);
        end
        idle(4);
        chk("t1_sat_count", int'(sat_count), 0);
        chk("t1_sat_flag", int'(sat_flag), 0);

        // Test 2: rounding at gain word 1 (1/16)
        set_gain(1, 16);
        tick(1'b1, 9, 1);
        tick(1'b1, -8, 1);
        tick(1'b1, -9, 1);
        tick(1'b1, 8, 1);
        idle(4);
        chk("t2_sat_count", int'(sat_count), 0);

        // Test 3: saturation at gain 2.0, then a clean pulse clears stats
        set_gain(32, 1);
        for (int i = 0; i < 10; i++) tick(1'b1, (i % 2 == 0) ? 30000 : -30000, 32);
        idle(4);
        chk("t3_sat_count", int'(sat_count), 10);
        chk("t3_sat_flag", int'(sat_flag), 1);
        for (int i = 0; i < 5; i++) tick(1'b1, 0, 32);
        idle(4);
        chk("t3_clean_count", int'(sat_count), 0);
        chk("t3_clean_flag", int'(sat_flag), 0);

        // Test 4: gain write mid-pulse waits for the gap
        set_gain(16, 32);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) tick(1'b1, 1000, 16, 1'b1, 20);
            else        tick(1'b1, 1000, 16);
            if (i == 5) begin
                chk("t4_mid_pending", int'(gain_pending), 1);
                chk("t4_mid_frozen", int'(gain_active), 16);
            end
        end
        idle(4);
        chk("t4_drain_frozen", int'(gain_active), 16);
        chk("t4_drain_pending", int'(gain_pending), 1);
        idle(1);
        chk("t4_applied", int'(gain_active), 20);
        chk("t4_applied_clr", int'(gain_pending), 0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1000, 20);
        idle(4);

        // Test 5: write on the rising strobe, back-to-back pulses keep it pending
        tick(1'b1, 30000, 20, 1'b1, 16);
        for (int i = 0; i < 4; i++) tick(1'b1, 30000, 20);
        chk("t5_pending_a", int'(gain_pending), 1);
        tick(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1000, 20);
            if (i == 2) begin
                chk("t5_b2b_count", int'(sat_count), 5);
                chk("t5_b2b_flag", int'(sat_flag), 1);
            end
        end
        idle(4);
        chk("t5_still_pending", int'(gain_pending), 1);
        chk("t5_still_old", int'(gain_active), 20);
        chk("t5_b_count", int'(sat_count), 0);
        idle(1);
        chk("t5_applied", int'(gain_active), 16);
        for (int i = 0; i < 3; i++) tick(1'b1, 1000, 16);
        idle(4);

        // Test 6: reset in the middle of a pulse with stats and a pending gain
        set_gain(24, 16);
        for (int i = 0; i < 3; i++) tick(1'b1, 30000, 24);
        idle(4);
        chk("t6_pre_count", int'(sat_count), 3);
        tick(1'b1, 1000, 24);
        tick(1'b1, 1000, 24);
        tick(1'b1, 1000, 24, 1'b1, 40);
        tick(1'b1, 1000, 24);
        chk("t6_pre_pending", int'(gain_pending), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0; store_strb = 1'b0; gain_wr = 1'b0; din = '0;
        sbq.delete();
        #1;
        chk("t6_rst_dout", int'(dout), 0);
        chk("t6_rst_strb_out", int'(store_strb_out), 0);
        chk("t6_rst_gain", int'(gain_active), 16);
        chk("t6_rst_pending", int'(gain_pending), 0);
        chk("t6_rst_count", int'(sat_count), 0);
        chk("t6_rst_flag", int'(sat_flag), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1000, 16);
            chk("t6_latency", int'(store_strb_out), (i >= 2) ? 1 : 0);
        end
        idle(5);
        chk("t6_post_count", int'(sat_count), 0);
        chk("t6_post_gain", int'(gain_active), 16);
        chk("t6_post_pending", int'(gain_pending), 0);
        chk("sb_drained", sbq.size(), 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
